// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue sitting between a 1-cycle-latency synchronous
// instruction memory and the decoder. It owns the fetch PC, issues sequential
// fetches (PC+4), buffers returned words together with their PCs in a
// DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
// A redirect flushes everything buffered or in flight and restarts fetching
// at redirect_pc.
//
// Optional feature (compile-time macro FETCH_QUEUE_BYPASS_EN):
//   Defined   - when the FIFO is empty, an arriving response is shown to decode
//               combinationally in the same cycle; if decode accepts it, it is
//               never written to the FIFO.
//   Undefined - every response is written to the FIFO first and becomes
//               visible to decode the following cycle.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   imem_req     out  fetch request this cycle
//   imem_addr    out  fetch address (the fetch PC)
//   imem_rdata   in   instruction word, valid the cycle after imem_req
//   instr_valid  out  head entry valid
//   instr        out  head instruction word
//   instr_pc     out  PC of the head instruction
//   instr_ready  in   decode accepts the head this cycle
//   redirect     in   flush and restart fetching at redirect_pc
//   redirect_pc  in   new fetch PC
//   count        out  number of entries held in the FIFO
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic                     instr_valid,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [PC_WIDTH-1:0]      instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PC_WIDTH-1:0]    fpc_reg;
  logic                   inflight_reg;
  logic [PC_WIDTH-1:0]    inflight_pc_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [AW-1:0]          wr_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic                   head_valid_reg;
  logic [INSTR_WIDTH-1:0] head_instr_reg;
  logic [PC_WIDTH-1:0]    head_pc_reg;

  logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
  logic [PC_WIDTH-1:0]    mem_pc    [DEPTH];

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic [CW:0]            occupancy;
  logic                   issue;
  logic                   resp_valid;
  logic                   bypass_hit;
  logic                   bypass_take;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          remaining;

  logic [AW-1:0]          rd_ptr_next;
  logic [AW-1:0]          wr_ptr_next;
  logic [CW-1:0]          count_next;
  logic                   head_valid_next;
  logic [INSTR_WIDTH-1:0] head_instr_next;
  logic [PC_WIDTH-1:0]    head_pc_next;

  // Entries already buffered plus the one that may still come back; a fetch
  // is only issued when that total leaves a free slot, so a push can never
  // find the FIFO full. The rst term keeps imem_req low while reset is held.
  assign occupancy = {1'b0, count_reg} + (CW+1)'(inflight_reg);
  assign issue     = rst && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = fpc_reg;

  // No fetch is issued in a redirect cycle, so inflight is always clear the
  // cycle after a redirect; the only response that can be stale is the one
  // arriving during the redirect cycle itself, and that is dropped below.
  assign resp_valid = inflight_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = resp_valid && (count_reg == '0) && !redirect;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit && instr_ready;
  assign pop         = head_valid_reg && instr_ready && !redirect;
  assign push        = resp_valid && !redirect && !bypass_take;
  assign remaining   = count_reg - CW'(pop);

  assign instr_valid = head_valid_reg || bypass_hit;
  assign instr       = bypass_hit ? imem_rdata      : head_instr_reg;
  assign instr_pc    = bypass_hit ? inflight_pc_reg : head_pc_reg;
  assign count       = count_reg;

  // Next-state for pointers, count and the registered head. The head
  // registers mirror mem[rd_ptr] whenever the FIFO is non-empty, and keep
  // their last value when it empties so instr/instr_pc hold.
  always_comb begin
    rd_ptr_next     = pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    wr_ptr_next     = push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    count_next      = count_reg + CW'(push) - CW'(pop);
    head_valid_next = head_valid_reg;
    head_instr_next = head_instr_reg;
    head_pc_next    = head_pc_reg;

    if (redirect) begin
      rd_ptr_next     = '0;
      wr_ptr_next     = '0;
      count_next      = '0;
      head_valid_next = 1'b0;
    end else if (remaining != '0) begin
      // An older entry stays behind after this cycle's pop: it becomes head.
      head_valid_next = 1'b1;
      head_instr_next = mem_instr[rd_ptr_next];
      head_pc_next    = mem_pc[rd_ptr_next];
    end else if (push) begin
      // FIFO drains to empty but a response is written now: it becomes head.
      head_valid_next = 1'b1;
      head_instr_next = imem_rdata;
      head_pc_next    = inflight_pc_reg;
    end else begin
      head_valid_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO storage (contents need no reset; validity is tracked by count)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_reg] <= imem_rdata;
      mem_pc[wr_ptr_reg]    <= inflight_pc_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_reg         <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      head_valid_reg  <= 1'b0;
      head_instr_reg  <= '0;
      head_pc_reg     <= '0;
    end else begin
      // Redirect wins over sequential advance; while redirect is held the
      // latest redirect_pc is captured each cycle.
      if (redirect) begin
        fpc_reg <= redirect_pc;
      end else if (issue) begin
        fpc_reg <= fpc_reg + PC_WIDTH'(4);
      end
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= fpc_reg;
      end
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= head_valid_next;
      head_instr_reg <= head_instr_next;
      head_pc_reg    <= head_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. A behavioural 1-cycle instruction memory
// answers each request with {addr, 16'h0013}. Whenever the bench starts or
// restarts fetching (reset release, redirect) it pushes the PC sequence it
// expects decode to receive into a scoreboard queue; every accepted handshake
// pops the queue and compares PC and instruction word.
// Build with +define+FETCH_QUEUE_BYPASS_EN for the bypass configuration.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int PW = 16;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 3;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [PW-1:0] instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [PW-1:0] exp_q[$];
  logic          req_now;
  logic [PW-1:0] addr_now;

  always #5 clk = ~clk;

  fetch_queue #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .count(count)
  );

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {a, 16'h0013};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_seq(input logic [PW-1:0] start, input int n);
    logic [PW-1:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pc);
      pc = pc + 16'd4;
    end
  endtask

  // First half of a cycle: entered 1 time unit after a rising edge with the
  // inputs already driven; ends at the falling edge after scoring any
  // handshake and latching the request for the memory model.
  task automatic half();
    logic [PW-1:0] e;
    #4;
    if (!redirect && instr_valid && instr_ready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_extra_pop: observed pc=%0h expected no entry", instr_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("[TB] t=%0t pop pc=%h instr=%h (exp pc=%h)", $time, instr_pc, instr, e);
        chk("pop_pc", 64'(instr_pc), 64'(e));
        chk("pop_instr", 64'(instr), 64'(mem_word(e)));
      end
      pops++;
    end
    req_now  = imem_req;
    addr_now = imem_addr;
  endtask

  // Second half: cross the rising edge and present the memory response.
  task automatic endc();
    @(posedge clk);
    #1;
    imem_rdata = req_now ? mem_word(addr_now) : 32'hDEAD_BEEF;
  endtask

  task automatic cycle();
    half();
    endc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_valid;
    bit found;

    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rdata  = '0;
    req_now     = 1'b0;
    addr_now    = '0;
    #1 rst = 1'b0;

    // ---- reset held for 3 cycles -------------------------------------
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", 64'(imem_req), 64'(0));
      chk("rst_valid", 64'(instr_valid), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      if (i == 0) begin
        chk("rst_instr", 64'(instr), 64'(0));
        chk("rst_pc", 64'(instr_pc), 64'(0));
        chk("rst_addr", 64'(imem_addr), 64'(16'h0000));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    expect_seq(16'h0000, 16);

    // ---- streaming with ready=1 -------------------------------------
    instr_ready = 1'b1;
    first_valid = -1;
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      half();
      if (c == 0) begin
        chk("first_req", 64'(imem_req), 64'(1));
        chk("first_addr", 64'(imem_addr), 64'(16'h0000));
      end
      if (instr_valid && first_valid < 0) first_valid = c;
      endc();
    end
    chk("first_valid_latency", 64'(first_valid), 64'(LAT));
    chk("stream_pops", 64'(pops), 64'(10 - LAT));

    // ---- asynchronous reset mid-stream ------------------------------
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(instr_valid), 64'(0));
    chk("async_rst_req", 64'(imem_req), 64'(0));
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_addr", 64'(imem_addr), 64'(16'h0000));
    @(posedge clk);
    #1;
    rst = 1'b1;
    instr_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    req_now = 1'b0;
    exp_q.delete();
    expect_seq(16'h0000, 16);

    // ---- fill with ready=0 ------------------------------------------
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      half();
      if (k == 0) chk("restart_addr", 64'(imem_addr), 64'(16'h0000));
      if (count == 3'd4) found = 1'b1;
      endc();
    end
    chk("fill_reached", 64'(found), 64'(1));
    for (int k = 0; k < 3; k++) begin
      half();
      chk("full_req", 64'(imem_req), 64'(0));
      chk("full_count", 64'(count), 64'(4));
      chk("full_head_pc", 64'(instr_pc), 64'(16'h0000));
      endc();
    end
    instr_ready = 1'b1;           // single pop from a full FIFO
    half();
    endc();
    instr_ready = 1'b0;
    half();
    chk("after_pop_count", 64'(count), 64'(3));
    chk("after_pop_head", 64'(instr_pc), 64'(16'h0004));
    chk("refill_req", 64'(imem_req), 64'(1));
    chk("refill_addr", 64'(imem_addr), 64'(16'h0010));
    endc();
    instr_ready = 1'b1;           // pop coincides with the 0x0010 response
    half();
    chk("inflight_req", 64'(imem_req), 64'(0));
    endc();
    instr_ready = 1'b0;
    half();
    chk("pushpop_count", 64'(count), 64'(3));
    chk("pushpop_head", 64'(instr_pc), 64'(16'h0008));
    chk("next_addr", 64'(imem_addr), 64'(16'h0014));
    endc();

    // ---- redirect with count=3 and 0x0014 in flight, held 2 cycles ---
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    exp_q.delete();
    expect_seq(16'h0100, 16);
    half();
    chk("redir_req", 64'(imem_req), 64'(0));
    endc();
    redirect_pc = 16'h0100;
    half();
    chk("redir_count", 64'(count), 64'(0));
    chk("redir_valid", 64'(instr_valid), 64'(0));
    chk("redir_hold_req", 64'(imem_req), 64'(0));
    endc();
    redirect = 1'b0;
    instr_ready = 1'b1;
    pops = 0;
    half();
    chk("redir_new_req", 64'(imem_req), 64'(1));
    chk("redir_new_addr", 64'(imem_addr), 64'(16'h0100));
    endc();
    for (int k = 0; k < 5; k++) cycle();
    chk("redir_stream_pops", 64'(pops), 64'(6 - LAT));

    // ---- redirect to 0xFFFC: PC wrap ---------------------------------
    redirect = 1'b1;
    redirect_pc = 16'hFFFC;
    exp_q.delete();
    expect_seq(16'hFFFC, 8);
    cycle();
    redirect = 1'b0;
    pops = 0;
    half();
    chk("wrap_addr", 64'(imem_addr), 64'(16'hFFFC));
    endc();
    half();
    chk("wrap_next_addr", 64'(imem_addr), 64'(16'h0000));
    endc();
    for (int k = 0; k < 6; k++) cycle();
    chk("wrap_pops", 64'(pops), 64'(8 - LAT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
